cpu_traffic_gen: RTL and testbench

- Synthesizable, parametrised CPU-side bus master that replaces hand-coded stimulus for the cache and memory subsystem.
- Replays a loadable script of NOP, WRITE, READ and READ_CHECK operations over the rd/wr/address/dataout/ready handshake.
- Checks read data against expected values, counts mismatches and aborts on a ready timeout.
- Sits at the CPU port of the cache in place of the processor, for bring-up and regression.

---
 rtl/cpu_tg_pkg.sv | 25 ++
 rtl/cpu_script_ram.sv | 24 ++
 rtl/cpu_traffic_gen.sv | 169 ++++++++++++++++
 tb/tb_cpu_traffic_gen.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_tg_pkg.sv
// Shared types for the CPU-side traffic generator:
// script op codes, FSM states and script entry width.
package cpu_tg_pkg;

  typedef enum logic [1:0] {
    OP_NOP        = 2'b00,
    OP_WRITE      = 2'b01,
    OP_READ       = 2'b10,
    OP_READ_CHECK = 2'b11
  } tg_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_ADV,
    ST_DONE
  } tg_state_e;

  // Entry layout is {op, adr, data}.
  function automatic int entry_w(input int adr_w, input int data_w);
    return 2 + adr_w + data_w;
  endfunction

endpackage

// File: rtl/cpu_script_ram.sv
// Script store: sync write port, sync read port, no reset.
// Ports: clk_i, we_i/waddr_i/wdata_i (write), raddr_i -> rdata_o (read).
module cpu_script_ram
  import cpu_tg_pkg::*;
#(
  parameter int AW = 4,
  parameter int W  = entry_w(16, 16)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [0:(1<<AW)-1];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/cpu_traffic_gen.sv
// CPU-side bus master replaying a loaded script of NOP/WRITE/READ/READ_CHECK.
// Ports: script load (ld_*), run control (start/length/busy/done), status
// (timeout_flag/err_cnt/err_first_idx/last_rdata), bus (address/dataout/
// datain/ready/rd/wr).
module cpu_traffic_gen
  import cpu_tg_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int ADR_WIDTH      = 16,
  parameter int SCRIPT_AW      = 4,
  parameter int TO_WIDTH       = 8,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ERR_WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_en,
  input  logic [SCRIPT_AW-1:0]  ld_idx,
  input  logic [1:0]            ld_op,
  input  logic [ADR_WIDTH-1:0]  ld_adr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  start,
  input  logic [SCRIPT_AW:0]    length,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_flag,
  output logic [ERR_WIDTH-1:0]  err_cnt,
  output logic [SCRIPT_AW-1:0]  err_first_idx,
  output logic [DATA_WIDTH-1:0] last_rdata,
  output logic [ADR_WIDTH-1:0]  address,
  output logic [DATA_WIDTH-1:0] dataout,
  input  logic [DATA_WIDTH-1:0] datain,
  input  logic                  ready,
  output logic                  rd,
  output logic                  wr
);

  localparam int EW = entry_w(ADR_WIDTH, DATA_WIDTH);
  localparam logic [SCRIPT_AW:0] DEPTH_L =
    {1'b1, {SCRIPT_AW{1'b0}}};
  localparam logic [TO_WIDTH-1:0] TO_LAST =
    TO_WIDTH'(TIMEOUT_CYCLES - 1);

  tg_state_e             st_q;
  logic [SCRIPT_AW-1:0]  idx_q;
  logic [SCRIPT_AW-1:0]  ridx;
  logic [SCRIPT_AW:0]    len_q;
  logic [TO_WIDTH-1:0]   tmr_q;
  logic [EW-1:0]         rentry;
  logic [1:0]            r_op;
  logic [ADR_WIDTH-1:0]  r_adr;
  logic [DATA_WIDTH-1:0] r_data;

  assign {r_op, r_adr, r_data} = rentry;

  // Read address tracks the index of the next state so the entry is
  // already on rentry during FETCH and stays there through WAIT.
  always_comb begin
    ridx = idx_q;
    if (st_q == ST_IDLE) ridx = '0;
    else if (st_q == ST_ADV) ridx = idx_q + 1'b1;
  end

  cpu_script_ram #(
    .AW (SCRIPT_AW),
    .W  (EW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ld_en && !busy),
    .waddr_i (ld_idx),
    .wdata_i ({ld_op, ld_adr, ld_data}),
    .raddr_i (ridx),
    .rdata_o (rentry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q          <= ST_IDLE;
      idx_q         <= '0;
      len_q         <= '0;
      tmr_q         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      timeout_flag  <= 1'b0;
      err_cnt       <= '0;
      err_first_idx <= '0;
      last_rdata    <= '0;
      address       <= '0;
      dataout       <= '0;
      rd            <= 1'b0;
      wr            <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (st_q)
        ST_IDLE: begin
          if (start) begin
            err_cnt       <= '0;
            err_first_idx <= '0;
            timeout_flag  <= 1'b0;
            last_rdata    <= '0;
            idx_q         <= '0;
            len_q <= (length > DEPTH_L) ? DEPTH_L : length;
            if (length == '0) begin
              done <= 1'b1;
              st_q <= ST_DONE;
            end else begin
              busy <= 1'b1;
              st_q <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          if (r_op == OP_NOP) begin
            st_q <= ST_ADV;
          end else begin
            address <= r_adr;
            rd      <= (r_op != OP_WRITE);
            wr      <= (r_op == OP_WRITE);
            dataout <= (r_op == OP_WRITE) ? r_data : '0;
            tmr_q   <= '0;
            st_q    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (ready) begin
            rd      <= 1'b0;
            wr      <= 1'b0;
            address <= '0;
            dataout <= '0;
            tmr_q   <= '0;
            st_q    <= ST_ADV;
            if (rd) begin
              last_rdata <= datain;
              if (r_op == OP_READ_CHECK && datain != r_data) begin
                if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                if (err_cnt == '0) err_first_idx <= idx_q;
              end
            end
          end else if (tmr_q == TO_LAST) begin
            rd           <= 1'b0;
            wr           <= 1'b0;
            address      <= '0;
            dataout      <= '0;
            tmr_q        <= '0;
            timeout_flag <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b1;
            st_q         <= ST_DONE;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        ST_ADV: begin
          if ({1'b0, idx_q} == len_q - 1'b1) begin
            busy <= 1'b0;
            done <= 1'b1;
            st_q <= ST_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
            st_q  <= ST_FETCH;
          end
        end
        ST_DONE: st_q <= ST_IDLE;
        default: st_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_traffic_gen.sv
// Self-checking bench for cpu_traffic_gen: bus memory responder,
// bus monitor and a script-level reference model.
module tb_cpu_traffic_gen;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld_en = 1'b0;
  logic [7:0]  ld_idx = '0;
  logic [1:0]  ld_op = '0;
  logic [15:0] ld_adr = '0;
  logic [15:0] ld_data = '0;
  logic        start = 1'b0;
  logic [8:0]  length = '0;
  logic        busy, done, timeout_flag;
  logic [7:0]  err_cnt, err_first_idx;
  logic [15:0] last_rdata, address, dataout;
  logic [15:0] datain = '0;
  logic        ready = 1'b0;
  logic        rd, wr;

  always #5 clk = ~clk;

  cpu_traffic_gen #(
    .DATA_WIDTH     (16),
    .ADR_WIDTH      (16),
    .SCRIPT_AW      (8),
    .TO_WIDTH       (8),
    .TIMEOUT_CYCLES (8),
    .ERR_WIDTH      (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ld_en         (ld_en),
    .ld_idx        (ld_idx),
    .ld_op         (ld_op),
    .ld_adr        (ld_adr),
    .ld_data       (ld_data),
    .start         (start),
    .length        (length),
    .busy          (busy),
    .done          (done),
    .timeout_flag  (timeout_flag),
    .err_cnt       (err_cnt),
    .err_first_idx (err_first_idx),
    .last_rdata    (last_rdata),
    .address       (address),
    .dataout       (dataout),
    .datain        (datain),
    .ready         (ready),
    .rd            (rd),
    .wr            (wr)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // script mirror and memory images
  logic [1:0]  scr_op  [DEPTH];
  logic [15:0] scr_adr [DEPTH];
  logic [15:0] scr_dat [DEPTH];
  logic [15:0] bmem [logic [15:0]];
  logic [15:0] refm [logic [15:0]];

  // responder controls
  bit hang = 0;
  bit stray = 0;
  bit corrupt = 0;
  int lmin = 1, lmax = 1;

  initial begin
    int rcnt, lat;
    rcnt = 0;
    lat = 1;
    forever begin
      @(negedge clk);
      if (rd || wr) begin
        rcnt++;
        if (!hang && rcnt >= lat) begin
          ready = 1'b1;
          if (wr) bmem[address] = dataout;
          else if (corrupt && address == 16'h0011) datain = 16'h1110;
          else datain = bmem.exists(address) ? bmem[address] : 16'h0;
        end else begin
          ready = 1'b0;
        end
      end else begin
        rcnt = 0;
        lat = $urandom_range(lmax, lmin);
        ready = stray ? 1'($urandom) : 1'b0;
        datain = 16'($urandom);
      end
    end
  end

  // bus monitor
  int done_n, rd_n, wr_n, rlen, gap;
  int stab_bad, gap_bad, idle_bad;
  logic [15:0] hadr, hdat;
  logic prq = 1'b0;

  initial begin
    gap = 100;
    forever begin
      @(negedge clk);
      if (done) done_n++;
      if ((rd || wr) && !prq) begin
        if (rd) rd_n++;
        if (wr) wr_n++;
        if (gap < 2) gap_bad++;
        hadr = address;
        hdat = dataout;
        rlen = 0;
      end
      if (rd || wr) begin
        rlen++;
        gap = 0;
        if (address != hadr || dataout != hdat) stab_bad++;
        if (rd && wr) stab_bad++;
      end else begin
        gap++;
        if (address != 0 || dataout != 0) idle_bad++;
      end
      prq = rd || wr;
    end
  end

  // reference model: run the script against a memory snapshot
  int e_err, e_first, e_wr, e_rd;
  logic [15:0] e_last;

  task automatic model(input int len);
    int n;
    logic [15:0] v;
    refm = bmem;
    n = (len > DEPTH) ? DEPTH : len;
    e_err = 0; e_first = 0; e_wr = 0; e_rd = 0; e_last = 0;
    for (int i = 0; i < n; i++) begin
      if (scr_op[i] == 2'b01) begin
        refm[scr_adr[i]] = scr_dat[i];
        e_wr++;
      end else if (scr_op[i] != 2'b00) begin
        if (corrupt && scr_adr[i] == 16'h0011) v = 16'h1110;
        else v = refm.exists(scr_adr[i]) ? refm[scr_adr[i]] : 16'h0;
        e_last = v;
        e_rd++;
        if (scr_op[i] == 2'b11 && v != scr_dat[i]) begin
          if (e_err == 0) e_first = i;
          if (e_err < 255) e_err++;
        end
      end
    end
  endtask

  task automatic ld(input int i, input logic [1:0] op,
                    input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    ld_en = 1'b1;
    ld_idx = 8'(i);
    ld_op = op;
    ld_adr = a;
    ld_data = d;
    scr_op[i] = op;
    scr_adr[i] = a;
    scr_dat[i] = d;
  endtask

  task automatic ld_end;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic load_basic;
    ld(0, 2'b01, 16'h0010, 16'h0751);
    ld(1, 2'b00, 16'h0000, 16'h0000);
    ld(2, 2'b00, 16'h0000, 16'h0000);
    ld(3, 2'b01, 16'h0011, 16'h1111);
    ld(4, 2'b01, 16'h0012, 16'h2222);
    ld(5, 2'b11, 16'h0010, 16'h0751);
    ld(6, 2'b11, 16'h0011, 16'h1111);
    ld(7, 2'b00, 16'h0000, 16'h0000);
    ld(8, 2'b11, 16'h0012, 16'h2222);
    ld_end;
  endtask

  task automatic run(input int len, input bit poke, input bit exp_to);
    int cyc;
    model(len);
    done_n = 0; rd_n = 0; wr_n = 0;
    stab_bad = 0; gap_bad = 0; idle_bad = 0;
    @(negedge clk);
    start = 1'b1;
    length = 9'(len);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 6000) begin
      if (poke && cyc == 3) begin
        start = 1'b1; length = 9'd1;
        ld_en = 1'b1; ld_idx = 8'd0; ld_op = 2'b00;
        ld_adr = 16'h0; ld_data = 16'hdead;
      end else if (poke && cyc == 4) begin
        start = 1'b0;
        ld_en = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", 32'(cyc < 6000), 1);
    if (len == 0) chk("len0_lat", cyc, 0);
    repeat (3) @(negedge clk);
    chk("done_n", done_n, 1);
    chk("busy_end", busy, 0);
    chk("to_flag", timeout_flag, 32'(exp_to));
    chk("stable", stab_bad, 0);
    chk("gap", gap_bad, 0);
    chk("idle_bus", idle_bad, 0);
    if (exp_to) begin
      chk("to_len", rlen, 8);
    end else begin
      chk("err_cnt", err_cnt, e_err);
      if (e_err != 0) chk("err_idx", err_first_idx, e_first);
      chk("last_rdata", last_rdata, e_last);
      chk("wr_n", wr_n, e_wr);
      chk("rd_n", rd_n, e_rd);
    end
  endtask

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd", rd, 0);
    chk("rst_wr", wr, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_adr", address, 0);
    rst = 1'b0;

    load_basic;
    run(9, 0, 0);
    corrupt = 1;
    run(9, 0, 0);
    corrupt = 0;

    lmin = 3; lmax = 5;
    run(9, 1, 0);
    run(9, 0, 0);
    run(0, 0, 0);

    ld(0, 2'b10, 16'h0010, 16'h0000);
    ld_end;
    hang = 1;
    run(1, 0, 1);
    hang = 0;

    load_basic;
    hang = 1;
    @(negedge clk);
    start = 1'b1;
    length = 9'd9;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(rd || wr) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("req_seen", 32'(rd || wr), 1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_rd", rd, 0);
    chk("arst_wr", wr, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    hang = 0;
    lmin = 1; lmax = 5;
    run(9, 0, 0);

    bmem.delete();
    for (int i = 0; i < DEPTH; i++)
      ld(i, 2'b11, 16'h0100 + 16'(i), 16'habcd);
    ld_end;
    run(256, 0, 0);

    stray = 1;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < DEPTH; i++)
        ld(i, 2'($urandom), 16'h0010 + 16'($urandom % 8),
           16'($urandom));
      ld_end;
      run((r == 0) ? 300 : int'($urandom_range(256, 1)), 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
